// File: rtl/imem_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads the combinational instruction
// memory and queues {pc, instr} in a 2-entry skid FIFO for decode.
module imem_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  localparam logic [32:0] LAST_LEGAL_PC = 33'(IMEM_BYTES) - 33'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;

  logic legal, deq, enq, take_fault;

  // 33-bit compare so a PC near 2^32 cannot wrap into the legal window.
  assign legal     = (pc_q[1:0] == 2'b00) && ({1'b0, pc_q} <= LAST_LEGAL_PC);
  assign out_valid = (count != 2'd0);
  assign deq       = out_valid & out_ready;
  assign imem_addr = pc_q;
  assign out_pc    = fifo_pc[rd_ptr];
  assign out_instr = fifo_instr[rd_ptr];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    enq        = 1'b0;
    take_fault = 1'b0;
    if (redirect_valid) begin
      state_d = RUN;
    end else if (state_q == RUN && fetch_en) begin
      if (!legal) begin
        state_d    = FAULT;
        take_fault = 1'b1;
      end else if (count < 2'd2 || deq) begin
        enq = 1'b1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= 32'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        // A same-cycle dequeue is simply absorbed by the flush.
        pc_q   <= redirect_pc;
        fault  <= 1'b0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (take_fault) begin
          fault    <= 1'b1;
          fault_pc <= pc_q;
        end
        if (enq) begin
          wr_ptr <= ~wr_ptr;
          pc_q   <= pc_q + 32'd4;
        end
        if (deq) rd_ptr <= ~rd_ptr;
        case ({enq, deq})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: FIFO storage is reset so the head reads as zero after reset, not stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= 32'd0;
        fifo_instr[i] <= 32'd0;
      end
    end else if (enq) begin
      fifo_pc[wr_ptr]    <= pc_q;
      fifo_instr[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: a byte-addressed memory model feeds
// imem_data, expected {pc, instr} pairs are queued and popped on each dequeue.
module tb_imem_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
  logic [31:0] fault_pc;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] sb [$];
  logic [63:0] exp_e;

  always #5 clk = ~clk;

  imem_fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(64)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fault(fault), .fault_pc(fault_pc)
  );

  function automatic logic [7:0] mem_byte(logic [31:0] a);
    logic [31:0] t;
    t = a * 32'd29 + 32'd7;
    return t[7:0] ^ 8'h3c;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
  endfunction

  assign imem_data = (imem_addr <= 32'd60 && imem_addr[1:0] == 2'b00)
                     ? mem_word(imem_addr) : 32'hdead_beef;

  task automatic push_exp(input logic [31:0] pc);
    sb.push_back({pc, mem_word(pc)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_pc !== 32'd0) $display("FAIL reset_out_pc: got %h want 0", out_pc); else n_pass++;
    n_checks++; if (out_instr !== 32'd0) $display("FAIL reset_out_instr: got %h want 0", out_instr); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else n_pass++;
    n_checks++; if (fault_pc !== 32'd0) $display("FAIL reset_fault_pc: got %h want 0", fault_pc); else n_pass++;
    n_checks++; if (imem_addr !== 32'd0) $display("FAIL reset_imem_addr: got %h want 0", imem_addr); else n_pass++;
    rst_n = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(32'(4 * k));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        $display("FAIL stream_valid[%0d]: got out_valid=%b want 1", k, out_valid);
      end else begin
        exp_e = sb.pop_front();
        if ({out_pc, out_instr} !== exp_e)
          $display("FAIL stream_entry[%0d]: got %h_%h want %h_%h", k, out_pc, out_instr, exp_e[63:32], exp_e[31:0]);
        else n_pass++;
      end
    end
    fetch_en = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_drained: got out_valid=%b want 0", out_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (imem_addr !== 32'd16) $display("FAIL fetch_en_hold: got %h want 00000010", imem_addr); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_exp(32'(4 * k));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || {out_pc, out_instr} !== sb[0])
        $display("FAIL bp_head_stable[%0d]: got v=%b %h_%h want v=1 %h_%h", k, out_valid, out_pc, out_instr, sb[0][63:32], sb[0][31:0]);
      else n_pass++;
    end
    n_checks++; if (imem_addr !== 32'd8) $display("FAIL bp_addr_hold: got %h want 00000008", imem_addr); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin
        $display("FAIL bp_release_valid[%0d]: got out_valid=%b want 1", k, out_valid);
      end else begin
        exp_e = sb.pop_front();
        if ({out_pc, out_instr} !== exp_e)
          $display("FAIL bp_release_entry[%0d]: got %h_%h want %h_%h", k, out_pc, out_instr, exp_e[63:32], exp_e[31:0]);
        else n_pass++;
      end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    push_exp(32'd0);
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h20; out_ready = 1'b1;
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_e)
      $display("FAIL redir_head: got v=%b %h_%h want v=1 %h_%h", out_valid, out_pc, out_instr, exp_e[63:32], exp_e[31:0]);
    else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL redir_flush: got out_valid=%b want 0", out_valid); else n_pass++;
    n_checks++; if (imem_addr !== 32'h20) $display("FAIL redir_addr: got %h want 00000020", imem_addr); else n_pass++;
    push_exp(32'h20);
    @(negedge clk);
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_e)
      $display("FAIL redir_target: got v=%b %h_%h want v=1 %h_%h", out_valid, out_pc, out_instr, exp_e[63:32], exp_e[31:0]);
    else n_pass++;
    fetch_en = 1'b0;
  endtask

  task automatic test_range_fault();
    int budget;
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) push_exp(32'(4 * k));
    budget = 40;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (out_valid) begin
        exp_e = sb.pop_front();
        n_checks++;
        if ({out_pc, out_instr} !== exp_e)
          $display("FAIL range_entry: got %h_%h want %h_%h", out_pc, out_instr, exp_e[63:32], exp_e[31:0]);
        else n_pass++;
      end
    end
    n_checks++; if (sb.size() != 0) $display("FAIL range_timeout: got %0d entries left want 0", sb.size()); else n_pass++;
    @(negedge clk);
    n_checks++; if (fault !== 1'b1) $display("FAIL range_fault: got %b want 1", fault); else n_pass++;
    n_checks++; if (fault_pc !== 32'd64) $display("FAIL range_fault_pc: got %h want 00000040", fault_pc); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL range_no_entry: got out_valid=%b want 0", out_valid); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'd64)
      $display("FAIL range_hold: got v=%b addr=%h want v=0 addr=00000040", out_valid, imem_addr);
    else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (fault !== 1'b0) $display("FAIL range_clear: got fault=%b want 0", fault); else n_pass++;
    n_checks++; if (fault_pc !== 32'd64) $display("FAIL range_fault_pc_hold: got %h want 00000040", fault_pc); else n_pass++;
    push_exp(32'd0);
    @(negedge clk);
    exp_e = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_e)
      $display("FAIL range_resume: got v=%b %h_%h want v=1 %h_%h", out_valid, out_pc, out_instr, exp_e[63:32], exp_e[31:0]);
    else n_pass++;
    fetch_en = 1'b0;
  endtask

  task automatic test_misaligned();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h6;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL misal_valid0: got %b want 0", out_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (fault !== 1'b1) $display("FAIL misal_fault: got %b want 1", fault); else n_pass++;
    n_checks++; if (fault_pc !== 32'h6) $display("FAIL misal_fault_pc: got %h want 00000006", fault_pc); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL misal_valid1: got %b want 0", out_valid); else n_pass++;
    fetch_en = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL midrst_pre_full: got %b want 1", out_valid); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'd0 || out_pc !== 32'd0)
      $display("FAIL midrst_state: got v=%b f=%b addr=%h pc=%h want v=0 f=0 addr=0 pc=0", out_valid, fault, imem_addr, out_pc);
    else n_pass++;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(32'(4 * k));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin
        $display("FAIL midrst_valid[%0d]: got %b want 1", k, out_valid);
      end else begin
        exp_e = sb.pop_front();
        if ({out_pc, out_instr} !== exp_e)
          $display("FAIL midrst_entry[%0d]: got %h_%h want %h_%h", k, out_pc, out_instr, exp_e[63:32], exp_e[31:0]);
        else n_pass++;
      end
    end
    fetch_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_range_fault();
    test_misaligned();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Instruction fetch front end: owns the PC and drives the byte address into the combinational instruction memory.
- Captures each returned 32-bit word into a 2-entry skid FIFO and presents {pc, instr} to decode over a valid/ready handshake.
- Handles redirects (branch/jump) with flush, and detects misaligned or out-of-range fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 64, instruction memory size in bytes; legal fetch iff pc+4 <= IMEM_BYTES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- fetch_en  input  1  1 = fetching allowed this cycle; 0 = hold PC, no enqueue
- imem_addr  output  32  byte address to instruction memory; always equals the PC register
- imem_data  input  32  word from memory, valid same cycle; byte at imem_addr in bits [31:24], imem_addr+3 in [7:0]
- redirect_valid  input  1  redirect request, higher priority than everything except reset
- redirect_pc  input  32  redirect target
- out_valid  output  1  FIFO head valid
- out_ready  input  1  decode accepts head when out_valid & out_ready
- out_pc  output  32  PC of head entry
- out_instr  output  32  instruction of head entry (imem_data taken unmodified)
- fault  output  1  sticky fetch fault
- fault_pc  output  32  PC that faulted

Behaviour:
- Reset (rst_n=0 at posedge): pc=RESET_PC, FIFO empty, out_valid=0, out_pc=0, out_instr=0, fault=0, fault_pc=0, state=RUN. A reset asserted mid-operation discards all FIFO contents and any pending redirect.
- States:
  - RUN: normal fetching.
  - FAULT: no fetching; FIFO keeps draining to decode.
- Legal fetch: pc[1:0]==0 and pc <= IMEM_BYTES-4 (compare with 33-bit arithmetic, no wrap).
- Enqueue condition: state==RUN & fetch_en & !redirect_valid & legal & (count<2 | (count==2 & deq)), where deq = out_valid & out_ready.
- On enqueue:
  - Write {pc, imem_data} to the FIFO tail.
  - pc <= pc+4, computed mod 2^32.
- Latency: a word fetched at cycle t is visible on out_* from cycle t+1. Throughput is 1 word/cycle with out_ready held high.
- Backpressure: while the FIFO is full and deq=0, pc holds and imem_addr is stable. The head entry and out_valid are stable while out_valid & !out_ready.
- RUN, fetch_en, !legal: state <= FAULT, fault <= 1, fault_pc <= pc, pc holds. No enqueue.
- Redirect (redirect_valid=1, any state):
  - FIFO flushed at the posedge, so out_valid=0 next cycle. A deq in the same cycle counts as consumed; the flush removes the rest.
  - pc <= redirect_pc, state <= RUN, fault <= 0, fault_pc holds.
  - No enqueue that cycle. The first fetch at the target occurs the next cycle, and its entry appears 2 cycles after the redirect.
- fetch_en=0: pc holds, no enqueue; dequeue continues normally.
- FIFO pointers are 1 bit each, count is 0..2. Simultaneous enqueue and dequeue at count 2 or count 1 leaves count unchanged. Dequeue at count 0 is impossible (out_valid=0).

Test Plan:
- Reset, then fetch_en=1, out_ready=1, memory holding words W0..W3 at 0,4,8,12 -> out_valid rises 1 cycle after reset release; out_pc sequence 0,4,8,12 on consecutive cycles; out_instr=W0..W3 with byte 0 in [31:24].
- Continuous fetch with out_ready=0 -> after 2 enqueues out_valid=1, head={0,W0} stable, imem_addr holds at 8; on out_ready=1, entries for 0,4,8 stream 1/cycle with no gap or duplicate.
- Redirect to 0x20 while FIFO holds 2 entries, with out_ready=1 in the same cycle -> head consumed, second entry dropped; out_valid=0 next cycle; the next out_pc is 0x20, 2 cycles after the redirect.
- PC reaches 60 with IMEM_BYTES=64 -> entry for 60 emitted; pc=64 triggers fault=1 and fault_pc=64, with no further entries. A redirect to 0 clears fault and fetching resumes at 0.
- Redirect to 0x06 -> fault=1, fault_pc=0x06, out_valid stays 0.
- Apply rst_n=0 for 1 cycle while full and backpressured -> next cycle out_valid=0, fault=0, imem_addr=RESET_PC; normal streaming resumes from RESET_PC.
